// File: rtl/mips_bus_pkg.sv
// Shared types for the CPU-side memory bus: arbiter state encoding and grant owner.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2,
    ACK   = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_INSTR = 1'b0,
    GRANT_DATA  = 1'b1
  } grant_t;

endpackage

// File: rtl/mips_mem_arbiter.sv
// Shares one Avalon-style word-addressed memory bus between the instruction-fetch
// and data load/store ports of the core, one transaction at a time.
//
// state | meaning
// IDLE  | arbitrate between eligible requesters
// ISSUE | command held on the bus until the slave accepts it
// RESP  | capture read data for the granted port
// ACK   | one-cycle ack pulse to the granted port
module mips_mem_arbiter
  import mips_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    instr_req,
  input  logic [ADDR_WIDTH-1:0]   instr_addr,
  output logic                    instr_ack,
  output logic [DATA_WIDTH-1:0]   instr_rdata,
  input  logic                    data_req,
  input  logic                    data_we,
  input  logic [ADDR_WIDTH-1:0]   data_addr,
  input  logic [DATA_WIDTH-1:0]   data_wdata,
  input  logic [DATA_WIDTH/8-1:0] data_byteenable,
  output logic                    data_ack,
  output logic [DATA_WIDTH-1:0]   data_rdata,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [DATA_WIDTH-1:0]   mem_writedata,
  output logic [DATA_WIDTH/8-1:0] mem_byteenable,
  input  logic                    mem_waitrequest,
  input  logic [DATA_WIDTH-1:0]   mem_readdata,
  output logic                    busy
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  arb_state_t            state_q, state_d;
  grant_t                grant_q, grant_d;
  grant_t                last_grant_q, last_grant_d;
  grant_t                pick;
  logic                  is_read_q, is_read_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BE_WIDTH-1:0]   be_q, be_d;
  logic [DATA_WIDTH-1:0] irdata_q, irdata_d;
  logic [DATA_WIDTH-1:0] drdata_q, drdata_d;
  logic                  iack_q, iack_d;
  logic                  dack_q, dack_d;
  logic                  instr_elig, data_elig;
  logic                  unused_addr_lsbs;

  // The bus is word addressed; byte offsets of the requester addresses are dropped.
  assign unused_addr_lsbs = ^{instr_addr[1:0], data_addr[1:0]};

  // A port whose ack is currently high is still holding req from the finished access.
  assign instr_elig = instr_req & ~iack_q;
  assign data_elig  = data_req & ~dack_q;

  // Two-way round robin: under contention the port not served last time wins.
  always_comb begin
    pick = GRANT_INSTR;
    if (instr_elig && data_elig) begin
      pick = (last_grant_q == GRANT_INSTR) ? GRANT_DATA : GRANT_INSTR;
    end else if (data_elig) begin
      pick = GRANT_DATA;
    end
  end

  // Next-state and registered-output logic of the transaction FSM.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    is_read_d    = is_read_q;
    addr_d       = addr_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    irdata_d     = irdata_q;
    drdata_d     = drdata_q;
    iack_d       = 1'b0;
    dack_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (instr_elig || data_elig) begin
          state_d      = ISSUE;
          grant_d      = pick;
          last_grant_d = pick;
          if (pick == GRANT_DATA) begin
            addr_d    = {data_addr[ADDR_WIDTH-1:2], 2'b00};
            rd_d      = ~data_we;
            wr_d      = data_we;
            is_read_d = ~data_we;
            be_d      = data_byteenable;
            wdata_d   = data_wdata;
          end else begin
            addr_d    = {instr_addr[ADDR_WIDTH-1:2], 2'b00};
            rd_d      = 1'b1;
            wr_d      = 1'b0;
            is_read_d = 1'b1;
            be_d      = '1;
          end
        end
      end
      ISSUE: begin
        if (!mem_waitrequest) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = RESP;
        end
      end
      RESP: begin
        if (is_read_q) begin
          if (grant_q == GRANT_DATA) drdata_d = mem_readdata;
          else                       irdata_d = mem_readdata;
        end
        iack_d  = (grant_q == GRANT_INSTR);
        dack_d  = (grant_q == GRANT_DATA);
        state_d = ACK;
      end
      ACK: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= GRANT_INSTR;
      last_grant_q <= GRANT_INSTR;
      is_read_q    <= 1'b0;
      addr_q       <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      wdata_q      <= '0;
      be_q         <= '0;
      irdata_q     <= '0;
      drdata_q     <= '0;
      iack_q       <= 1'b0;
      dack_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      is_read_q    <= is_read_d;
      addr_q       <= addr_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      irdata_q     <= irdata_d;
      drdata_q     <= drdata_d;
      iack_q       <= iack_d;
      dack_q       <= dack_d;
    end
  end

  assign mem_address    = addr_q;
  assign mem_read       = rd_q;
  assign mem_write      = wr_q;
  assign mem_writedata  = wdata_q;
  assign mem_byteenable = be_q;
  assign instr_rdata    = irdata_q;
  assign data_rdata     = drdata_q;
  assign instr_ack      = iack_q;
  assign data_ack       = dack_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: doc/mips_mem_arbiter.md
# mips_mem_arbiter

Two-requester memory arbiter that shares one Avalon-style, single-port, word-addressed memory bus between the CPU's instruction-fetch port and its data load/store port. It sits between the CPU core and external memory, converting the core's split Harvard-style accesses into one bus transaction at a time. It provides request/acknowledge handshakes on both core ports, alternating fairness under contention, and correct holding of bus signals under `mem_waitrequest`.

## Interface
- `ADDR_WIDTH`, 32, byte-address width on all ports
- `DATA_WIDTH`, 32, data width; byteenable width is `DATA_WIDTH/8`
- `clk`  in  1  single clock; everything samples on posedge
- `reset`  in  1  asynchronous, active-high
- `instr_req`  in  1  fetch request, held until `instr_ack`
- `instr_addr`  in  ADDR_WIDTH  fetch byte address
- `instr_ack`  out  1  one-cycle pulse: fetch complete, `instr_rdata` valid
- `instr_rdata`  out  DATA_WIDTH  fetched word, registered
- `data_req`  in  1  load/store request, held until `data_ack`
- `data_we`  in  1  1 = store, 0 = load; stable while `data_req`
- `data_addr`  in  ADDR_WIDTH  load/store byte address
- `data_wdata`  in  DATA_WIDTH  store data
- `data_byteenable`  in  DATA_WIDTH/8  store/load byte lanes
- `data_ack`  out  1  one-cycle pulse: access complete, `data_rdata` valid for loads
- `data_rdata`  out  DATA_WIDTH  loaded word, registered
- `mem_address`  out  ADDR_WIDTH  word-aligned bus address, registered
- `mem_read`, `mem_write`  out  1  bus command strobes, registered, never both high
- `mem_writedata`  out  DATA_WIDTH  registered store data
- `mem_byteenable`  out  DATA_WIDTH/8  registered byte lanes
- `mem_waitrequest`  in  1  slave stall; a command is accepted in a cycle where it is high and waitrequest is low
- `mem_readdata`  in  DATA_WIDTH  valid in the cycle after read acceptance
- `busy`  out  1  high whenever state ≠ IDLE

## Operation
- FSM states:
  - IDLE: arbitrate.
  - ISSUE: command driven on the bus.
  - RESP: capture/complete.
  - ACK: pulse the requester.
- IDLE → ISSUE when an eligible request exists. A requester is ineligible in the cycle its own ack is high, which prevents re-granting a request that is still held high.
- Arbitration:
  - Only one request eligible: grant it.
  - Both eligible: grant the opposite of `last_grant`.
  - `last_grant` updates on every grant and resets to INSTR, so data wins the first contention.
- On entering ISSUE, register the bus fields from the granted port:
  - `mem_address = {addr[ADDR_WIDTH-1:2], 2'b00}`.
  - Fetch: `mem_read=1`, `mem_byteenable` all ones.
  - Data: `mem_read = !data_we`, `mem_write = data_we`, `mem_byteenable = data_byteenable`, `mem_writedata = data_wdata`.
- ISSUE holds all bus outputs constant while `mem_waitrequest=1`. On acceptance, go to RESP and drop both strobes on the same edge.
- RESP (exactly 1 cycle): for a read, latch `mem_readdata` into the granted port's rdata register. For a write, rdata is unchanged. Then go to ACK.
- ACK (exactly 1 cycle): assert the granted port's ack. Then go to IDLE.
- Requester inputs other than `req` are sampled only at grant; later changes have no effect on the transaction in flight.

## Timing
- Request first visible in IDLE at cycle N: strobes are high from N+1. With acceptance at cycle A (A = N+1 when there are no waits), RESP is at A+1 and ack is at A+2. The minimum request-to-ack latency is 3 cycles.
- Back-to-back throughput: one transaction per 4 cycles with zero waitstates.
- A requester must deassert `req` in the cycle after its ack, or present a new request there. The arbiter re-samples from IDLE.
- Reset (asynchronous, any state):
  - Return to IDLE.
  - `mem_read`, `mem_write`, `instr_ack`, `data_ack`, `busy` = 0.
  - `mem_address`, `mem_writedata`, `instr_rdata`, `data_rdata` = 0.
  - `mem_byteenable` = 0.
  - `last_grant` = INSTR.
  - An in-flight transaction is abandoned and no ack is issued.
- `mem_readdata` is ignored outside RESP.

## Structure
- Package `mips_bus_pkg`: `arb_state_t` {IDLE, ISSUE, RESP, ACK} and `grant_t` {GRANT_INSTR, GRANT_DATA}; shared with the later bus-wrapper top.
- Single module; no sub-module. The two-way round-robin pick is a few lines of combinational logic inside the module.

## Test plan
- Fetch only, `instr_addr=0xBFC00002`, waitrequest 0, readdata 0x12345678 → `mem_address=0xBFC00000`, `mem_read` high 1 cycle, `instr_ack` 3 cycles after req with `instr_rdata=0x12345678`.
- Store `data_addr=0x100`, wdata 0xDEADBEEF, byteenable 4'b0011, 3 waitrequest cycles → strobe and fields held stable for 4 cycles, `data_ack` 6 cycles after req, `mem_read` never high.
- Both requests held from reset release → grant order DATA, INSTR, DATA, INSTR; each ack arrives 4 cycles after the previous one.
- Requester keeps `instr_req` high through the ack cycle and the next cycle → exactly one extra fetch is issued; no fetch is issued in the ack cycle itself.
- Assert `reset` mid-ISSUE with waitrequest high → `mem_read` goes to 0 asynchronously, no ack is issued, and the first grant after release is to the data port if both requests are pending.
- Load with readdata changing during ISSUE and after RESP → `data_rdata` equals the value present in the RESP cycle only.
